otter_mmio_timer: RTL and testbench

Memory-mapped I/O responder on the OTTER data-memory port (port 2). It serves CPU loads and stores in the I/O window: a switch input register, an LED output register, and a prescaled 32-bit timer with compare-match interrupt. Read latency is one cycle, the same as the synchronous data memory, so the MEM_WB stage captures I/O reads with no change to the pipeline. Out-of-window accesses are ignored and return zero, so `IO_DOUT` can be OR-merged with the memory read data.

---
 rtl/otter_mmio_timer.sv | 182 ++++++++++++++++++
 tb/tb_otter_mmio_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : otter_mmio_timer
// Description : OTTER data-port MMIO responder: switches, LEDs and a
//               prescaled 32-bit compare-match timer with level interrupt.
// Revision    : 1.0
// ============================================================================
module otter_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          IO_ADDR,
    input  logic [31:0]          IO_DIN,
    input  logic                 IO_WRITE,
    input  logic                 IO_READ,
    input  logic [1:0]           IO_SIZE,
    output logic [31:0]          IO_DOUT,
    output logic                 IO_ERR,
    input  logic [SW_WIDTH-1:0]  IO_SW,
    output logic [LED_WIDTH-1:0] IO_LEDS,
    output logic                 IO_IRQ
);

    localparam logic [7:0] C_OFF_SW    = 8'h00;
    localparam logic [7:0] C_OFF_LEDS  = 8'h04;
    localparam logic [7:0] C_OFF_COUNT = 8'h08;
    localparam logic [7:0] C_OFF_CMP   = 8'h0C;
    localparam logic [7:0] C_OFF_CTRL  = 8'h10;
    localparam logic [7:0] C_OFF_PRESC = 8'h14;
    localparam logic [1:0] C_SIZE_WORD = 2'd2;

    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          cmp_q, cmp_d;
    logic                 en_q, en_d;
    logic                 reload_q, reload_d;
    logic                 match_q, match_d;
    logic                 ie_q, ie_d;
    logic [15:0]          presc_q, presc_d;
    logic [15:0]          pcnt_q, pcnt_d;
    logic [31:0]          dout_q, dout_d;
    logic                 err_q, err_d;

    logic        w_hit;
    logic [7:0]  w_off;
    logic        w_mapped;
    logic        w_err;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_tick;
    logic        w_eq;
    logic [31:0] w_rdata;

    assign w_hit = (IO_ADDR[31:8] == BASE_ADDR[31:8]);
    assign w_off = IO_ADDR[7:0];

    always_comb begin
        w_mapped = 1'b0;
        case (w_off)
            C_OFF_SW, C_OFF_LEDS, C_OFF_COUNT,
            C_OFF_CMP, C_OFF_CTRL, C_OFF_PRESC: w_mapped = 1'b1;
            default:                            w_mapped = 1'b0;
        endcase
    end

    assign w_err   = w_hit && (IO_READ || IO_WRITE) &&
                     ((IO_SIZE != C_SIZE_WORD) || (IO_ADDR[1:0] != 2'b00) || !w_mapped);
    assign w_wr_ok = w_hit && IO_WRITE && !w_err;
    assign w_rd_ok = w_hit && IO_READ && !w_err;

    assign w_tick = en_q && (pcnt_q == presc_q);
    assign w_eq   = (count_q == cmp_q);

    // Read mux sees pre-write register values, so same-cycle read/write returns old data.
    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            C_OFF_SW:    w_rdata = 32'(sw_sync_q);
            C_OFF_LEDS:  w_rdata = 32'(leds_q);
            C_OFF_COUNT: w_rdata = count_q;
            C_OFF_CMP:   w_rdata = cmp_q;
            C_OFF_CTRL:  w_rdata = {28'h0, ie_q, match_q, reload_q, en_q};
            C_OFF_PRESC: w_rdata = {16'h0, presc_q};
            default:     w_rdata = 32'h0;
        endcase
    end

    always_comb begin
        leds_d   = leds_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        reload_d = reload_q;
        ie_d     = ie_q;
        presc_d  = presc_q;
        count_d  = count_q;
        match_d  = match_q;
        pcnt_d   = pcnt_q;

        if (!en_q || (w_wr_ok && (w_off == C_OFF_PRESC))) begin
            pcnt_d = 16'h0;
        end else if (w_tick) begin
            pcnt_d = 16'h0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        if (w_tick) begin
            count_d = (w_eq && reload_q) ? 32'h0 : count_q + 32'd1;
        end

        if (w_wr_ok) begin
            case (w_off)
                C_OFF_LEDS:  leds_d  = IO_DIN[LED_WIDTH-1:0];
                C_OFF_COUNT: count_d = IO_DIN;
                C_OFF_CMP:   cmp_d   = IO_DIN;
                C_OFF_CTRL: begin
                    en_d     = IO_DIN[0];
                    reload_d = IO_DIN[1];
                    ie_d     = IO_DIN[3];
                    if (IO_DIN[2]) begin
                        match_d = 1'b0;
                    end
                end
                C_OFF_PRESC: presc_d = IO_DIN[15:0];
                default: ;
            endcase
        end

        // A hardware match set overrides a simultaneous write-1-to-clear.
        if (w_tick && w_eq) begin
            match_d = 1'b1;
        end
    end

    always_comb begin
        dout_d = w_rd_ok ? w_rdata : 32'h0;
        err_d  = w_err;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            leds_q    <= '0;
            count_q   <= 32'h0;
            cmp_q     <= 32'h0;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            match_q   <= 1'b0;
            ie_q      <= 1'b0;
            presc_q   <= 16'h0;
            pcnt_q    <= 16'h0;
            dout_q    <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= IO_SW;
            sw_sync_q <= sw_meta_q;
            leds_q    <= leds_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            en_q      <= en_d;
            reload_q  <= reload_d;
            match_q   <= match_d;
            ie_q      <= ie_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
        end
    end

    assign IO_DOUT = dout_q;
    assign IO_ERR  = err_q;
    assign IO_LEDS = leds_q;
    assign IO_IRQ  = match_q && ie_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_mmio_timer
// Description : Directed scoreboard bench for otter_mmio_timer.
// Revision    : 1.0
// ============================================================================
module tb_otter_mmio_timer;

    localparam logic [31:0] C_BASE  = 32'h1100_0000;
    localparam logic [31:0] C_SW    = 32'h00;
    localparam logic [31:0] C_LEDS  = 32'h04;
    localparam logic [31:0] C_COUNT = 32'h08;
    localparam logic [31:0] C_CMP   = 32'h0C;
    localparam logic [31:0] C_CTRL  = 32'h10;
    localparam logic [31:0] C_PRESC = 32'h14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] io_addr;
    logic [31:0] io_din;
    logic        io_write;
    logic        io_read;
    logic [1:0]  io_size;
    logic [31:0] io_dout;
    logic        io_err;
    logic [15:0] io_sw;
    logic [15:0] io_leds;
    logic        io_irq;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic pend;

    otter_mmio_timer #(
        .BASE_ADDR (C_BASE),
        .SW_WIDTH  (16),
        .LED_WIDTH (16)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .IO_ADDR  (io_addr),
        .IO_DIN   (io_din),
        .IO_WRITE (io_write),
        .IO_READ  (io_read),
        .IO_SIZE  (io_size),
        .IO_DOUT  (io_dout),
        .IO_ERR   (io_err),
        .IO_SW    (io_sw),
        .IO_LEDS  (io_leds),
        .IO_IRQ   (io_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= io_read | io_write;
    end

    // Every access produces one response cycle; all other cycles must be quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $error("FAIL sb_underflow: response with no expectation dout=%h err=%b", io_dout, io_err);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    assert (io_dout === e.dout && io_err === e.err) else begin
                        n_fail++;
                        $error("FAIL %s: observed dout=%h err=%b expected dout=%h err=%b",
                               e.tag, io_dout, io_err, e.dout, e.err);
                    end
                end
            end else begin
                n_tests++;
                assert (io_dout === 32'h0 && io_err === 1'b0) else begin
                    n_fail++;
                    $error("FAIL idle: observed dout=%h err=%b expected dout=0 err=0", io_dout, io_err);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        io_write = 1'b0;
        io_read  = 1'b0;
        io_addr  = 32'h0;
        io_din   = 32'h0;
        io_size  = 2'd2;
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] size,
                       input logic [31:0] exp_dout, input logic exp_err, input string tag);
        io_write = wr;
        io_read  = rd;
        io_addr  = addr;
        io_din   = din;
        io_size  = size;
        if (wr || rd) q.push_back('{tag, exp_dout, exp_err});
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic wr32(input logic [31:0] off, input logic [31:0] data, input string tag);
        cyc(1'b1, 1'b0, C_BASE + off, data, 2'd2, 32'h0, 1'b0, tag);
    endtask

    task automatic rd32(input logic [31:0] off, input logic [31:0] exp, input string tag);
        cyc(1'b0, 1'b1, C_BASE + off, 32'h0, 2'd2, exp, 1'b0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        io_sw = 16'h0;
        clr_inputs();
        idle(3);
        chk("rst_dout", io_dout, 32'h0);
        chk("rst_leds", 32'(io_leds), 32'h0);
        chk("rst_irq", 32'(io_irq), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // LED write and read-back
        wr32(C_LEDS, 32'h0000_A5A5, "led_wr");
        chk("led_out", 32'(io_leds), 32'h0000_A5A5);
        rd32(C_LEDS, 32'h0000_A5A5, "led_rd");
        idle(1);

        // Timer with reload: PRESC=3, CMP=2
        wr32(C_PRESC, 32'd3, "presc_wr");
        wr32(C_CMP, 32'd2, "cmp_wr");
        wr32(C_CTRL, 32'hB, "ctrl_wr_b");
        rd32(C_COUNT, 32'd0, "tmr_cnt0");
        idle(3);
        rd32(C_COUNT, 32'd1, "tmr_cnt1");
        idle(3);
        rd32(C_COUNT, 32'd2, "tmr_cnt2");
        idle(2);
        chk("irq_before_match", 32'(io_irq), 32'h0);
        idle(1);
        chk("irq_at_match", 32'(io_irq), 32'h1);
        rd32(C_COUNT, 32'd0, "tmr_reloaded");
        rd32(C_CTRL, 32'hF, "ctrl_match_set");
        wr32(C_CTRL, 32'hF, "ctrl_w1c");
        chk("irq_cleared", 32'(io_irq), 32'h0);
        wr32(C_CTRL, 32'h0, "ctrl_off");

        // Free-run wrap, PRESC=0
        wr32(C_PRESC, 32'd0, "presc0");
        wr32(C_COUNT, 32'hFFFF_FFFE, "cnt_wr");
        wr32(C_CMP, 32'd5, "cmp5");
        wr32(C_CTRL, 32'h1, "ctrl_en");
        rd32(C_COUNT, 32'hFFFF_FFFE, "wrap_fffe");
        rd32(C_COUNT, 32'hFFFF_FFFF, "wrap_ffff");
        rd32(C_COUNT, 32'h0000_0000, "wrap_0");
        rd32(C_COUNT, 32'h0000_0001, "wrap_1");
        rd32(C_CTRL, 32'h1, "wrap_nomatch_a");
        idle(2);
        rd32(C_CTRL, 32'h1, "wrap_nomatch_b");
        rd32(C_CTRL, 32'h5, "wrap_match5");
        chk("irq_masked", 32'(io_irq), 32'h0);
        wr32(C_CTRL, 32'h0, "ctrl_off_keep");
        rd32(C_CTRL, 32'h4, "match_kept");
        rd32(C_COUNT, 32'd8, "cnt_frozen");

        // Access errors leave LEDS unchanged
        cyc(1'b1, 1'b0, C_BASE + 32'h04, 32'h0000_FFFF, 2'd0, 32'h0, 1'b1, "err_byte_store");
        cyc(1'b0, 1'b1, C_BASE + 32'h06, 32'h0, 2'd2, 32'h0, 1'b1, "err_misaligned");
        cyc(1'b0, 1'b1, C_BASE + 32'h40, 32'h0, 2'd2, 32'h0, 1'b1, "err_unmapped");
        chk("leds_after_err", 32'(io_leds), 32'h0000_A5A5);
        rd32(C_LEDS, 32'h0000_A5A5, "leds_rd_after_err");

        // Switch synchronizer and out-of-window access
        io_sw = 16'h1234;
        idle(3);
        rd32(C_SW, 32'h0000_1234, "sw_rd");
        wr32(C_SW, 32'hFFFF_FFFF, "sw_wr_ignored");
        rd32(C_SW, 32'h0000_1234, "sw_rd_again");
        cyc(1'b0, 1'b1, 32'h1000_0000, 32'h0, 2'd2, 32'h0, 1'b0, "miss_rd");

        // Match set beats a simultaneous write-1-to-clear
        wr32(C_CTRL, 32'h4, "ctrl_clr");
        rd32(C_CTRL, 32'h0, "ctrl_cleared");
        wr32(C_COUNT, 32'd0, "cnt0");
        wr32(C_CMP, 32'd0, "cmp0");
        wr32(C_CTRL, 32'h3, "ctrl_en_rl");
        wr32(C_CTRL, 32'hF, "ctrl_w1c_vs_set");
        rd32(C_CTRL, 32'hF, "match_set_wins");
        chk("irq_set_wins", 32'(io_irq), 32'h1);
        wr32(C_COUNT, 32'h100, "cnt_wr_tick");
        rd32(C_COUNT, 32'h100, "cnt_write_wins");
        cyc(1'b1, 1'b1, C_BASE + C_LEDS, 32'h0000_5A5A, 2'd2, 32'h0000_A5A5, 1'b0, "rw_same_reg");
        chk("leds_new", 32'(io_leds), 32'h0000_5A5A);

        // Asynchronous reset with a read in flight
        io_read = 1'b1;
        io_addr = C_BASE + C_COUNT;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clr_inputs();
        #1;
        q.delete();
        chk("arst_dout", io_dout, 32'h0);
        chk("arst_err", 32'(io_err), 32'h0);
        chk("arst_leds", 32'(io_leds), 32'h0);
        chk("arst_irq", 32'(io_irq), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd32(C_COUNT, 32'h0, "post_rst_count");
        rd32(C_CTRL, 32'h0, "post_rst_ctrl");
        rd32(C_LEDS, 32'h0, "post_rst_leds");
        idle(2);

        chk("sb_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
